// File: rtl/cortex_lb_hub.sv
// Local-bus hub: one master port fanned out to NUM_CHILDREN-1 child blocks, with an internal
// register file at block 0, a staggered per-child reset sequencer and a response timeout.
module cortex_lb_hub #(
  parameter int unsigned LB_DATA_W      = 32,
  parameter int unsigned LB_ADDR_W      = 16,
  parameter int unsigned LB_ADDR_BLK_W  = 4,
  parameter int unsigned NUM_CHILDREN   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned RST_STAGGER    = 4,
  parameter logic [LB_DATA_W-1:0] DEFAULT_DATA_VAL = 'hdeadbabe
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    lb_wr_en,
  input  logic                                    lb_rd_en,
  input  logic [LB_ADDR_W-1:0]                    lb_addr,
  input  logic [LB_DATA_W-1:0]                    lb_wr_data,
  output logic                                    lb_wr_valid,
  output logic                                    lb_rd_valid,
  output logic [LB_DATA_W-1:0]                    lb_rd_data,
  output logic [NUM_CHILDREN-2:0]                 chld_lb_wr_en,
  output logic [NUM_CHILDREN-2:0]                 chld_lb_rd_en,
  output logic [LB_ADDR_W-LB_ADDR_BLK_W-1:0]      chld_lb_addr,
  output logic [LB_DATA_W-1:0]                    chld_lb_wr_data,
  input  logic [NUM_CHILDREN-2:0]                 chld_lb_wr_valid,
  input  logic [NUM_CHILDREN-2:0]                 chld_lb_rd_valid,
  input  logic [(NUM_CHILDREN-1)*LB_DATA_W-1:0]   chld_lb_rd_data,
  output logic [NUM_CHILDREN-2:0]                 chld_rst
);

  localparam int unsigned NCH     = NUM_CHILDREN - 1;
  localparam int unsigned CA_W    = LB_ADDR_W - LB_ADDR_BLK_W;
  localparam int unsigned SEQ_MAX = RST_STAGGER * NCH;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]               state;
  logic [SEQ_W-1:0]         seq_cnt;
  logic [NCH-1:0]           seq_done;
  logic [NCH-1:0]           rst_ctrl;
  logic                     st_timeout;
  logic                     st_fault;
  logic [3:0]               st_blk;
  logic                     txn_wr;
  logic [LB_ADDR_BLK_W-1:0] txn_blk;
  logic [NCH-1:0]           txn_hot;
  logic [TO_W-1:0]          to_cnt;

  logic [LB_ADDR_BLK_W-1:0] blk;
  logic [CA_W-1:0]          caddr;
  logic                     req;
  logic                     blk_is_zero;
  logic [NCH-1:0]           blk_hot;
  logic                     child_go;
  logic                     sel_valid;
  logic [LB_DATA_W-1:0]     sel_data;
  logic [LB_DATA_W-1:0]     status_word;
  logic [LB_DATA_W-1:0]     local_data;

  assign blk         = lb_addr[LB_ADDR_W-1 -: LB_ADDR_BLK_W];
  assign caddr       = lb_addr[CA_W-1:0];
  assign req         = lb_wr_en | lb_rd_en;
  assign blk_is_zero = (blk == '0);
  assign chld_rst    = ~seq_done | rst_ctrl;
  assign child_go    = |(blk_hot & ~chld_rst);

  always_comb begin
    seq_done = '0;
    blk_hot  = '0;
    sel_data = '0;
    for (int unsigned j = 0; j < NCH; j++) begin
      seq_done[j] = (32'(seq_cnt) >= RST_STAGGER * (j + 1));
      blk_hot[j]  = (32'(blk) == j + 1);
      if (txn_hot[j]) sel_data = chld_lb_rd_data[j*LB_DATA_W +: LB_DATA_W];
    end
  end

  // Only the valid matching the pending transaction type from the selected child counts.
  assign sel_valid = txn_wr ? |(txn_hot & chld_lb_wr_valid) : |(txn_hot & chld_lb_rd_valid);

  always_comb begin
    status_word       = '0;
    status_word[0]    = st_timeout;
    status_word[1]    = st_fault;
    status_word[11:8] = st_blk;
    local_data        = DEFAULT_DATA_VAL;
    case (caddr)
      CA_W'(0): local_data = LB_DATA_W'(rst_ctrl);
      CA_W'(1): local_data = status_word;
      CA_W'(2): local_data = LB_DATA_W'(32'h0C0B_0001);
      default:  local_data = DEFAULT_DATA_VAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      seq_cnt         <= '0;
      rst_ctrl        <= '0;
      st_timeout      <= 1'b0;
      st_fault        <= 1'b0;
      st_blk          <= '0;
      txn_wr          <= 1'b0;
      txn_blk         <= '0;
      txn_hot         <= '0;
      to_cnt          <= '0;
      lb_wr_valid     <= 1'b0;
      lb_rd_valid     <= 1'b0;
      lb_rd_data      <= '0;
      chld_lb_wr_en   <= '0;
      chld_lb_rd_en   <= '0;
      chld_lb_addr    <= '0;
      chld_lb_wr_data <= '0;
    end else begin
      if (seq_cnt != SEQ_W'(SEQ_MAX)) seq_cnt <= seq_cnt + 1'b1;
      lb_wr_valid   <= 1'b0;
      lb_rd_valid   <= 1'b0;
      chld_lb_wr_en <= '0;
      chld_lb_rd_en <= '0;

      case (state)
        IDLE: begin
          if (req && child_go) begin
            chld_lb_wr_en   <= lb_wr_en ? blk_hot : '0;
            chld_lb_rd_en   <= lb_wr_en ? '0 : blk_hot;
            chld_lb_addr    <= caddr;
            chld_lb_wr_data <= lb_wr_data;
            txn_wr          <= lb_wr_en;
            txn_blk         <= blk;
            txn_hot         <= blk_hot;
            to_cnt          <= '0;
            state           <= WAIT;
          end else if (req) begin
            // Local, unmapped or held-child access: answered next cycle without a child strobe.
            lb_wr_valid <= lb_wr_en;
            lb_rd_valid <= ~lb_wr_en;
            if (!lb_wr_en) lb_rd_data <= blk_is_zero ? local_data : DEFAULT_DATA_VAL;
            if (blk_is_zero) begin
              if (lb_wr_en && caddr == CA_W'(0)) rst_ctrl <= lb_wr_data[NCH-1:0];
              if (lb_wr_en && caddr == CA_W'(1)) begin
                st_timeout <= 1'b0;
                st_fault   <= 1'b0;
                st_blk     <= '0;
              end
            end else begin
              st_fault <= 1'b1;
              st_blk   <= 4'(blk);
            end
            state <= RESP;
          end
        end
        WAIT: begin
          if (sel_valid) begin
            lb_wr_valid <= txn_wr;
            lb_rd_valid <= ~txn_wr;
            if (!txn_wr) lb_rd_data <= sel_data;
            state <= RESP;
          end else if (to_cnt == TO_W'(TIMEOUT_CYCLES)) begin
            lb_wr_valid <= txn_wr;
            lb_rd_valid <= ~txn_wr;
            if (!txn_wr) lb_rd_data <= DEFAULT_DATA_VAL;
            st_timeout <= 1'b1;
            st_blk     <= 4'(txn_blk);
            state      <= RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cortex_lb_hub.sv
// Scoreboard bench for cortex_lb_hub: expected responses are queued at issue time and
// compared when the hub raises a master valid.
module tb_cortex_lb_hub;

  logic        clk = 1'b0;
  logic        rst;
  logic        lb_wr_en, lb_rd_en;
  logic [15:0] lb_addr;
  logic [31:0] lb_wr_data;
  logic        lb_wr_valid, lb_rd_valid;
  logic [31:0] lb_rd_data;
  logic [2:0]  chld_lb_wr_en, chld_lb_rd_en;
  logic [11:0] chld_lb_addr;
  logic [31:0] chld_lb_wr_data;
  logic [2:0]  chld_lb_wr_valid, chld_lb_rd_valid;
  logic [95:0] chld_lb_rd_data;
  logic [2:0]  chld_rst;

  logic [2:0]  mdl_rd_valid, mdl_wr_valid, spur_rd;
  assign chld_lb_rd_valid = mdl_rd_valid | spur_rd;
  assign chld_lb_wr_valid = mdl_wr_valid;

  cortex_lb_hub #(
    .LB_DATA_W(32), .LB_ADDR_W(16), .LB_ADDR_BLK_W(4), .NUM_CHILDREN(4),
    .TIMEOUT_CYCLES(64), .RST_STAGGER(4), .DEFAULT_DATA_VAL(32'hdeadbabe)
  ) dut (
    .clk(clk), .rst(rst), .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr),
    .lb_wr_data(lb_wr_data), .lb_wr_valid(lb_wr_valid), .lb_rd_valid(lb_rd_valid),
    .lb_rd_data(lb_rd_data), .chld_lb_wr_en(chld_lb_wr_en), .chld_lb_rd_en(chld_lb_rd_en),
    .chld_lb_addr(chld_lb_addr), .chld_lb_wr_data(chld_lb_wr_data),
    .chld_lb_wr_valid(chld_lb_wr_valid), .chld_lb_rd_valid(chld_lb_rd_valid),
    .chld_lb_rd_data(chld_lb_rd_data), .chld_rst(chld_rst)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  bit          got, grd;
  logic [31:0] gdata;
  int          gcyc;

  // Child responder: answers a strobe child_dly cycles later (0 = never answers).
  int          child_dly[3];
  logic [31:0] child_dat[3];
  int          rem[3];
  bit          kind_rd[3];

  initial begin
    mdl_rd_valid    = '0;
    mdl_wr_valid    = '0;
    chld_lb_rd_data = '0;
    for (int j = 0; j < 3; j++) begin
      rem[j] = 0; kind_rd[j] = 0;
    end
    forever begin
      @(posedge clk); #1;
      mdl_rd_valid = '0;
      mdl_wr_valid = '0;
      for (int j = 0; j < 3; j++) begin
        if (rem[j] > 0) begin
          rem[j]--;
          if (rem[j] == 0) begin
            if (kind_rd[j]) begin
              mdl_rd_valid[j] = 1'b1;
              chld_lb_rd_data[j*32 +: 32] = child_dat[j];
            end else begin
              mdl_wr_valid[j] = 1'b1;
            end
          end
        end else if ((chld_lb_rd_en[j] || chld_lb_wr_en[j]) && child_dly[j] > 0) begin
          rem[j]     = child_dly[j];
          kind_rd[j] = chld_lb_rd_en[j];
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input bit wr, input bit rd, input logic [15:0] addr, input logic [31:0] data);
    lb_wr_en = wr; lb_rd_en = rd; lb_addr = addr; lb_wr_data = data;
    step();
    lb_wr_en = 1'b0; lb_rd_en = 1'b0;
  endtask

  // Collects the next master response (no checking); leaves the hub back in IDLE.
  task automatic wait_resp(input int budget);
    got = 0; grd = 0; gdata = '0; gcyc = -1;
    for (int i = 0; i < budget && !got; i++) begin
      if (lb_rd_valid || lb_wr_valid) begin
        got = 1; grd = lb_rd_valid; gdata = lb_rd_data; gcyc = cyc;
      end
      step();
    end
  endtask

  task automatic push(input bit rd, input logic [31:0] data, input int at);
    exp_t x;
    x.rd = rd; x.data = data; x.cyc = at;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    rst = 1'b1; lb_wr_en = 0; lb_rd_en = 0; lb_addr = '0; lb_wr_data = '0; spur_rd = '0;
    for (int j = 0; j < 3; j++) begin
      child_dly[j] = 0; child_dat[j] = '0;
    end
    repeat (3) step();
    total++;
    if ({lb_wr_valid, lb_rd_valid, chld_lb_wr_en, chld_lb_rd_en, chld_rst, lb_rd_data} !== {2'b00, 6'b0, 3'b111, 32'h0}) begin
      bad++;
      $display("FAIL reset_state: valids=%b%b strobes=%b/%b chld_rst=%b rd_data=%h, need 00 000/000 111 00000000",
               lb_wr_valid, lb_rd_valid, chld_lb_wr_en, chld_lb_rd_en, chld_rst, lb_rd_data);
    end
    rst = 1'b0;
    for (int k = 0; k < 14; k++) begin
      logic [2:0] want;
      for (int j = 0; j < 3; j++) want[j] = (k < 4 * (j + 1));
      total++;
      if (chld_rst !== want) begin
        bad++;
        $display("FAIL stagger cycle %0d: chld_rst=%b need %b", k, chld_rst, want);
      end
      step();
    end
  endtask

  task automatic test_regs();
    total++;
    if (chld_rst !== 3'b000) begin
      bad++; $display("FAIL rst_ctrl_pre: chld_rst=%b need 000", chld_rst);
    end
    push(0, 32'h0, cyc + 1);
    issue(1, 0, 16'h0000, 32'h1);
    total++;
    if (chld_rst !== 3'b001) begin
      bad++; $display("FAIL rst_ctrl_assert: chld_rst=%b need 001", chld_rst);
    end
    wait_resp(10);
    e = sb.pop_front(); total++;
    if ({got, grd, gcyc} !== {1'b1, e.rd, e.cyc}) begin
      bad++; $display("FAIL rst_ctrl_wr: got=%0d rd=%0d cyc=%0d need rd=%0d cyc=%0d", got, grd, gcyc, e.rd, e.cyc);
    end
    for (int i = 0; i < 3; i++) begin
      logic [15:0] a;
      logic [31:0] v;
      a = (i == 0) ? 16'h0000 : (i == 1) ? 16'h0002 : 16'h0001;
      v = (i == 0) ? 32'h1 : (i == 1) ? 32'h0C0B0001 : 32'h0;
      push(1, v, cyc + 1);
      issue(0, 1, a, 32'h0);
      wait_resp(10);
      e = sb.pop_front(); total++;
      if ({got, grd, gcyc, gdata} !== {1'b1, e.rd, e.cyc, e.data}) begin
        bad++; $display("FAIL reg_read addr %h: got=%0d rd=%0d cyc=%0d data=%h need cyc=%0d data=%h",
                        a, got, grd, gcyc, gdata, e.cyc, e.data);
      end
    end
    push(0, 32'h0, cyc + 1);
    issue(1, 0, 16'h0000, 32'h0);
    wait_resp(10);
    e = sb.pop_front(); total++;
    if ({got, grd, gcyc, chld_rst} !== {1'b1, e.rd, e.cyc, 3'b000}) begin
      bad++; $display("FAIL rst_ctrl_release: got=%0d cyc=%0d chld_rst=%b need cyc=%0d 000", got, gcyc, chld_rst, e.cyc);
    end
  endtask

  task automatic test_child_read();
    child_dly[1] = 3; child_dat[1] = 32'h0000A5A5;
    push(1, 32'h0000A5A5, cyc + 5);
    issue(0, 1, 16'h2005, 32'h0);
    total++;
    if ({chld_lb_rd_en, chld_lb_wr_en, chld_lb_addr} !== {3'b010, 3'b000, 12'h005}) begin
      bad++; $display("FAIL child_rd_strobe: rd_en=%b wr_en=%b addr=%h need 010 000 005", chld_lb_rd_en, chld_lb_wr_en, chld_lb_addr);
    end
    spur_rd = 3'b001;
    step();
    spur_rd = 3'b000;
    wait_resp(20);
    e = sb.pop_front(); total++;
    if ({got, grd, gcyc, gdata} !== {1'b1, e.rd, e.cyc, e.data}) begin
      bad++; $display("FAIL child_rd: got=%0d rd=%0d cyc=%0d data=%h need cyc=%0d data=%h", got, grd, gcyc, gdata, e.cyc, e.data);
    end
  endtask

  task automatic test_child_write();
    child_dly[0] = 2;
    push(0, 32'h0, cyc + 4);
    issue(1, 0, 16'h1010, 32'h12345678);
    total++;
    if ({chld_lb_wr_en, chld_lb_rd_en, chld_lb_addr, chld_lb_wr_data} !== {3'b001, 3'b000, 12'h010, 32'h12345678}) begin
      bad++; $display("FAIL child_wr_strobe: wr_en=%b rd_en=%b addr=%h data=%h need 001 000 010 12345678",
                      chld_lb_wr_en, chld_lb_rd_en, chld_lb_addr, chld_lb_wr_data);
    end
    wait_resp(20);
    e = sb.pop_front(); total++;
    if ({got, grd, gcyc} !== {1'b1, e.rd, e.cyc}) begin
      bad++; $display("FAIL child_wr: got=%0d rd=%0d cyc=%0d need rd=0 cyc=%0d", got, grd, gcyc, e.cyc);
    end
  endtask

  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      logic [31:0] want_data, want_status;
      issue(1, 0, 16'h0001, 32'hFFFF);
      wait_resp(10);
      child_dly[2] = (pass == 0) ? 0 : 64;
      child_dat[2] = 32'h5A5A0003;
      want_data    = (pass == 0) ? 32'hdeadbabe : 32'h5A5A0003;
      want_status  = (pass == 0) ? 32'h301 : 32'h0;
      push(1, want_data, cyc + 66);
      issue(0, 1, 16'h3000, 32'h0);
      wait_resp(80);
      e = sb.pop_front(); total++;
      if ({got, grd, gcyc, gdata} !== {1'b1, e.rd, e.cyc, e.data}) begin
        bad++; $display("FAIL timeout pass %0d: got=%0d cyc=%0d data=%h need cyc=%0d data=%h", pass, got, gcyc, gdata, e.cyc, e.data);
      end
      push(1, want_status, cyc + 1);
      issue(0, 1, 16'h0001, 32'h0);
      wait_resp(10);
      e = sb.pop_front(); total++;
      if ({got, gdata} !== {1'b1, e.data}) begin
        bad++; $display("FAIL timeout_status pass %0d: data=%h need %h", pass, gdata, e.data);
      end
    end
    child_dly[2] = 0;
    spur_rd = 3'b100;
    step();
    spur_rd = 3'b000;
    total++;
    if ({lb_rd_valid, lb_wr_valid} !== 2'b00) begin
      bad++; $display("FAIL late_valid: valids=%b%b need 00", lb_rd_valid, lb_wr_valid);
    end
    step();
  endtask

  task automatic test_fault();
    push(1, 32'hdeadbabe, cyc + 1);
    issue(0, 1, 16'h5000, 32'h0);
    wait_resp(10);
    e = sb.pop_front(); total++;
    if ({got, grd, gcyc, gdata} !== {1'b1, e.rd, e.cyc, e.data}) begin
      bad++; $display("FAIL unmapped_rd: got=%0d cyc=%0d data=%h need cyc=%0d data=%h", got, gcyc, gdata, e.cyc, e.data);
    end
    push(1, 32'h502, cyc + 1);
    issue(0, 1, 16'h0001, 32'h0);
    wait_resp(10);
    e = sb.pop_front(); total++;
    if (gdata !== e.data) begin
      bad++; $display("FAIL unmapped_status: data=%h need %h", gdata, e.data);
    end
    issue(1, 0, 16'h0001, 32'h1234);
    wait_resp(10);
    push(1, 32'h0, cyc + 1);
    issue(0, 1, 16'h0001, 32'h0);
    wait_resp(10);
    e = sb.pop_front(); total++;
    if (gdata !== e.data) begin
      bad++; $display("FAIL status_clear: data=%h need %h", gdata, e.data);
    end
    issue(1, 0, 16'h0000, 32'h1);
    wait_resp(10);
    push(1, 32'hdeadbabe, cyc + 1);
    issue(0, 1, 16'h1004, 32'h0);
    total++;
    if ({chld_lb_rd_en, chld_lb_wr_en} !== 6'b0) begin
      bad++; $display("FAIL held_strobe: rd_en=%b wr_en=%b need 000 000", chld_lb_rd_en, chld_lb_wr_en);
    end
    wait_resp(10);
    e = sb.pop_front(); total++;
    if ({got, grd, gcyc, gdata} !== {1'b1, e.rd, e.cyc, e.data}) begin
      bad++; $display("FAIL held_rd: got=%0d cyc=%0d data=%h need cyc=%0d data=%h", got, gcyc, gdata, e.cyc, e.data);
    end
    push(1, 32'h102, cyc + 1);
    issue(0, 1, 16'h0001, 32'h0);
    wait_resp(10);
    e = sb.pop_front(); total++;
    if (gdata !== e.data) begin
      bad++; $display("FAIL held_status: data=%h need %h", gdata, e.data);
    end
    issue(1, 0, 16'h0000, 32'h0);
    wait_resp(10);
  endtask

  task automatic test_back_to_back();
    push(1, 32'h0C0B0001, cyc + 1);
    issue(0, 1, 16'h0002, 32'h0);
    e = sb.pop_front(); total++;
    if ({lb_rd_valid, cyc, lb_rd_data} !== {1'b1, e.cyc, e.data}) begin
      bad++; $display("FAIL b2b_first: valid=%b cyc=%0d data=%h need cyc=%0d data=%h", lb_rd_valid, cyc, lb_rd_data, e.cyc, e.data);
    end
    issue(0, 1, 16'h0000, 32'h0);
    total++;
    if ({lb_rd_valid, lb_wr_valid} !== 2'b00) begin
      bad++; $display("FAIL b2b_ignored: valids=%b%b need 00", lb_rd_valid, lb_wr_valid);
    end
    push(1, 32'h0, cyc + 1);
    issue(0, 1, 16'h0000, 32'h0);
    wait_resp(10);
    e = sb.pop_front(); total++;
    if ({got, grd, gcyc, gdata} !== {1'b1, e.rd, e.cyc, e.data}) begin
      bad++; $display("FAIL b2b_second: got=%0d cyc=%0d data=%h need cyc=%0d data=%h", got, gcyc, gdata, e.cyc, e.data);
    end
    push(0, 32'h0, cyc + 1);
    issue(1, 1, 16'h0000, 32'h0);
    wait_resp(10);
    e = sb.pop_front(); total++;
    if ({got, grd, gcyc} !== {1'b1, e.rd, e.cyc}) begin
      bad++; $display("FAIL wr_rd_both: got=%0d rd=%0d cyc=%0d need rd=0 cyc=%0d", got, grd, gcyc, e.cyc);
    end
  endtask

  task automatic test_rst_in_wait();
    bit seen;
    issue(0, 1, 16'h3000, 32'h0);
    total++;
    if (chld_lb_rd_en !== 3'b100) begin
      bad++; $display("FAIL wait_strobe: rd_en=%b need 100", chld_lb_rd_en);
    end
    repeat (3) step();
    rst = 1'b1;
    step();
    total++;
    if ({chld_lb_rd_en, chld_lb_wr_en, lb_rd_valid, lb_wr_valid, chld_rst} !== {6'b0, 2'b00, 3'b111}) begin
      bad++; $display("FAIL rst_in_wait: strobes=%b/%b valids=%b%b chld_rst=%b need 000/000 00 111",
                      chld_lb_rd_en, chld_lb_wr_en, lb_rd_valid, lb_wr_valid, chld_rst);
    end
    rst = 1'b0;
    repeat (3) step();
    total++;
    if (chld_rst !== 3'b111) begin
      bad++; $display("FAIL restart_c3: chld_rst=%b need 111", chld_rst);
    end
    step();
    total++;
    if (chld_rst !== 3'b110) begin
      bad++; $display("FAIL restart_c4: chld_rst=%b need 110", chld_rst);
    end
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (lb_rd_valid || lb_wr_valid) seen = 1;
      step();
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL dropped_txn: stray master valid seen=%0d need 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_child_read();
    test_child_write();
    test_timeout();
    test_fault();
    test_back_to_back();
    test_rst_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
